// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control unit for the model computer datapath. It fetches an
//   opcode over the instruction-memory handshake, decodes it into an
//   instruction class, and then steps through FETCH/DECODE/EXEC/MEM/WB. Along
//   the way it issues one-cycle strobes to the PC, register file, ALU and
//   data RAM.
//
//   Handshakes (both memories): the controller raises *_req and holds it
//   every cycle until the matching *_ready is seen high on a rising edge. The
//   transfer completes on that edge. A *_ready outside its request state is
//   ignored.
//
//   Optional build macro: CTRL_TIMEOUT_EN enables a MEM-wait watchdog. After
//   TIMEOUT_CYC MEM cycles without mem_ready it sets the sticky err flag and
//   aborts the instruction. The aborted instruction is not counted in retired.
//
//   Outputs are decoded from the registered state and IR. ir_load also
//   follows imem_ready. In EXEC, pc_mux follows flag_z. In MEM, pc_en follows
//   mem_ready. While rst is high, every output is forced to 0.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   imem_req/imem_ready   instruction fetch handshake, instr_op = opcode
//   flag_z                ALU zero flag, used by conditional branches in EXEC
//   mem_req/mem_we        data RAM request / write qualifier
//   mem_ready             data RAM access complete
//   ir_load               IR capture strobe (same cycle as imem_ready)
//   pc_en/pc_mux/bias_mux PC update strobe, source select, offset select
//   reg_we/reg_mux        register write strobe, writeback source
//   a_mux/alu_op          ALU A-operand select and operation
//   busy/halted/err       status: executing, HALT reached, MEM timeout
//   retired               count of completed instructions (wraps)
//
//   Internal signal `state` (type state_t) holds the FSM state.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int OP_W        = 4,
   parameter int ALU_W       = 3,
   parameter int RET_W       = 16,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   input  logic             imem_ready,
   input  logic [OP_W-1:0]  instr_op,
   input  logic             flag_z,
   output logic             mem_req,
   output logic             mem_we,
   input  logic             mem_ready,
   output logic             ir_load,
   output logic             pc_en,
   output logic [2:0]       pc_mux,
   output logic             bias_mux,
   output logic             reg_we,
   output logic [1:0]       reg_mux,
   output logic             a_mux,
   output logic [ALU_W-1:0] alu_op,
   output logic             busy,
   output logic             halted,
   output logic             err,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_IMM, C_LDR, C_STORE, C_HALT, C_BRANCH
   } cls_t;

   localparam logic [OP_W-1:0] STORE_OP = {OP_W{1'b1}};
   localparam logic [OP_W-1:0] HALT_OP  = {{(OP_W-1){1'b1}}, 1'b0};

   state_t          state;
   cls_t            cls;
   logic [OP_W-1:0] ir;
   logic            timeout_hit;   // watchdog abort in the current MEM cycle

   function automatic cls_t classify(input logic [OP_W-1:0] op);
      if (!op[OP_W-1])   return C_ALU;
      if (!op[OP_W-2])   return op[0] ? C_LDR : C_IMM;
      if (op == STORE_OP) return C_STORE;
      if (op == HALT_OP)  return C_HALT;
      return C_BRANCH;
   endfunction

`ifdef CTRL_TIMEOUT_EN
   localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 4) ? $clog2(TIMEOUT_CYC + 1) : 4;
   logic [TO_W-1:0] to_cnt;   // MEM cycles seen so far without mem_ready
`endif

   // Output decode. pc_en marks the final cycle of every instruction.
   always_comb begin
      imem_req    = 1'b0;
      ir_load     = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      pc_en       = 1'b0;
      pc_mux      = 3'b000;
      bias_mux    = 1'b0;
      reg_we      = 1'b0;
      reg_mux     = 2'b00;
      a_mux       = 1'b0;
      alu_op      = '0;
      busy        = 1'b0;
      halted      = 1'b0;
      timeout_hit = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_load  = imem_ready;
               busy     = imem_ready;   // idle only while waiting for an opcode
            end
            S_DECODE: busy = 1'b1;
            S_EXEC: begin
               busy = 1'b1;
               case (cls)
                  C_ALU: begin
                     alu_op  = ir[ALU_W-1:0];
                     reg_mux = 2'b11;
                     reg_we  = 1'b1;
                     pc_en   = 1'b1;
                  end
                  C_IMM: begin
                     reg_mux = 2'b00;
                     a_mux   = 1'b1;
                     reg_we  = 1'b1;
                     pc_en   = 1'b1;
                  end
                  C_LDR:   reg_mux = 2'b01;
                  C_BRANCH: begin
                     pc_en    = 1'b1;
                     bias_mux = ir[1];
                     // Unconditional when IR[0]=0, otherwise taken on zero.
                     pc_mux   = (!ir[0] || flag_z) ? ir[2:0] : 3'b000;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               busy    = 1'b1;
               mem_req = 1'b1;
               mem_we  = (cls == C_STORE);
               if (mem_ready) begin
                  pc_en = (cls == C_STORE);
               end
`ifdef CTRL_TIMEOUT_EN
               else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  timeout_hit = 1'b1;
                  pc_en       = 1'b1;
               end
`endif
            end
            S_WB: begin
               busy    = 1'b1;
               reg_we  = 1'b1;
               reg_mux = 2'b01;
               pc_en   = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_FETCH;
         ir      <= '0;
         cls     <= C_ALU;
         retired <= '0;
         err     <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
         to_cnt  <= '0;
`endif
      end else begin
         if (pc_en && !timeout_hit) retired <= retired + RET_W'(1);
         case (state)
            S_FETCH: if (imem_ready) begin
               ir    <= instr_op;
               state <= S_DECODE;
            end
            S_DECODE: begin
               cls   <= classify(ir);
               state <= (classify(ir) == C_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: state <= (cls == C_LDR || cls == C_STORE) ? S_MEM : S_FETCH;
            S_MEM: begin
               if (mem_ready) state <= (cls == C_STORE) ? S_FETCH : S_WB;
               else if (timeout_hit) begin
                  state <= S_FETCH;
                  err   <= 1'b1;
               end
`ifdef CTRL_TIMEOUT_EN
               to_cnt <= (mem_ready || timeout_hit) ? '0 : to_cnt + TO_W'(1);
`endif
            end
            S_WB:    state <= S_FETCH;
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each instruction's expected final-cycle
//   strobes and latency are computed from the opcode when it is issued. They
//   are queued, then popped and compared when the DUT raises pc_en. The
//   retired counter is narrowed to 4 bits so that the wrap from 15 to 0 is
//   exercised.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
   localparam int OP_W        = 4;
   localparam int ALU_W       = 3;
   localparam int RET_W       = 4;
   localparam int TIMEOUT_CYC = 15;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             imem_req, imem_ready = 1'b0;
   logic [OP_W-1:0]  instr_op = '0;
   logic             flag_z = 1'b0;
   logic             mem_req, mem_we, mem_ready = 1'b0;
   logic             ir_load, pc_en, bias_mux, reg_we, a_mux;
   logic [2:0]       pc_mux;
   logic [1:0]       reg_mux;
   logic [ALU_W-1:0] alu_op;
   logic             busy, halted, err;
   logic [RET_W-1:0] retired;

   multicycle_ctrl #(
      .OP_W(OP_W), .ALU_W(ALU_W), .RET_W(RET_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_ready(imem_ready), .instr_op(instr_op),
      .flag_z(flag_z),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready),
      .ir_load(ir_load), .pc_en(pc_en), .pc_mux(pc_mux), .bias_mux(bias_mux),
      .reg_we(reg_we), .reg_mux(reg_mux), .a_mux(a_mux), .alu_op(alu_op),
      .busy(busy), .halted(halted), .err(err), .retired(retired)
   );

   // clock / reset
   always #5 clk = ~clk;

   int               n_cmp = 0;
   int               n_bad = 0;
   logic [11:0]      exp_q[$];
   int               lat_q[$];
   logic [RET_W-1:0] exp_ret = '0;
   logic             exp_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] snap();
      return {reg_we, reg_mux, a_mux, alu_op, pc_mux, bias_mux, mem_we};
   endfunction

   function automatic logic [31:0] all_outs();
      return {9'd0, imem_req, mem_req, mem_we, ir_load, pc_en, pc_mux, bias_mux,
              reg_we, reg_mux, a_mux, alu_op, busy, halted, err, retired};
   endfunction

   // Reference: final-cycle strobes, cycles from ir_load to pc_en, MEM cycles.
   // mdly < 0 means mem_ready never arrives.
   function automatic void model(input logic [3:0] op, input logic fz, input int mdly,
                                 output logic [11:0] s, output int lat, output int mcyc);
      logic taken;
      s    = '0;
      mcyc = 0;
      lat  = 2;
      if (!op[3]) begin
         s = {1'b1, 2'b11, 1'b0, op[2:0], 3'b000, 1'b0, 1'b0};
      end else if (!op[2]) begin
         if (!op[0]) begin
            s = {1'b1, 2'b00, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
         end else if (mdly < 0) begin
            lat  = 3 + TIMEOUT_CYC - 1;
            mcyc = TIMEOUT_CYC;
         end else begin
            s    = {1'b1, 2'b01, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
            lat  = 4 + mdly;
            mcyc = mdly + 1;
         end
      end else if (op == 4'b1111) begin
         s    = {1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1};
         lat  = 3 + mdly;
         mcyc = mdly + 1;
      end else begin
         taken = !op[0] || fz;
         s = {1'b0, 2'b00, 1'b0, 3'b000, taken ? op[2:0] : 3'b000, op[1], 1'b0};
      end
   endfunction

   // Driver: issue one instruction from FETCH-idle and follow it to completion.
   task automatic run_instr(input logic [3:0] op, input logic fz, input int mdly);
      logic [11:0] s;
      int lat, mcyc, c, mseen;
      bit got, we_seen;
      model(op, fz, mdly, s, lat, mcyc);
      exp_q.push_back(s);
      lat_q.push_back(lat);
      instr_op   = op;
      flag_z     = fz;
      imem_ready = 1'b1;
      mem_ready  = 1'b0;
      #1;
      chk("ir_load_c0", {31'd0, ir_load}, 32'd1);
      c = 0; mseen = 0; got = 0; we_seen = 0;
      while (!got && c < 60) begin
         tick();
         c++;
         imem_ready = 1'b0;
         if (mem_req) begin
            we_seen   = we_seen | mem_we;
            mem_ready = (mdly >= 0 && mseen == mdly);
            mseen++;
         end else begin
            mem_ready = 1'b0;
         end
         #1;
         if (pc_en) begin
            got = 1;
            chk("final_strobes", {20'd0, snap()}, {20'd0, exp_q.pop_front()});
            chk("latency", c, lat_q.pop_front());
         end
      end
      if (!got) begin
         chk("pc_en_never_seen", 32'd0, 32'd1);
         void'(exp_q.pop_front());
         void'(lat_q.pop_front());
      end
      chk("mem_req_cycles", mseen, mcyc);
      chk("mem_we_seen", {31'd0, we_seen}, {31'd0, (op == 4'b1111)});
      if (mdly < 0 && op[3:2] == 2'b10 && op[0]) exp_err = 1'b1;
      else exp_ret = exp_ret + RET_W'(1);
      tick();
      mem_ready = 1'b0;
      flag_z    = 1'b0;
      #1;
      chk("retired", retired, exp_ret);
      chk("err", {31'd0, err}, {31'd0, exp_err});
      chk("imem_req_next", {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      logic [3:0] op;
      // Reset state, checked while rst is still held.
      rst = 1'b1;
      tick(); tick(); tick();
      chk("reset_outs", all_outs(), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_reset_imem_req", {31'd0, imem_req}, 32'd1);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);

      run_instr(4'b0101, 1'b0, 0);   // ALU
      run_instr(4'b1101, 1'b0, 0);   // branch not taken
      run_instr(4'b1101, 1'b1, 0);   // branch taken on zero
      run_instr(4'b1100, 1'b0, 0);   // unconditional branch
      run_instr(4'b1001, 1'b0, 3);   // RAM load, ready after 3 waits
      run_instr(4'b1001, 1'b0, 0);   // RAM load, ready at once
      run_instr(4'b1000, 1'b0, 0);   // immediate load
      run_instr(4'b1111, 1'b0, 0);   // store
      run_instr(4'b1111, 1'b0, 2);   // store with waits
      run_instr(4'b0010, 1'b1, 0);   // ALU op 010

      // Random mix; runs retired past 15 back through 0.
      for (int i = 0; i < 10; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'b1110) op = 4'b0110;
         run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

`ifdef CTRL_TIMEOUT_EN
      run_instr(4'b1001, 1'b0, -1);  // RAM load, mem_ready never arrives
      run_instr(4'b0001, 1'b0, 0);   // err stays set
`endif

      // Reset held 2 cycles in the middle of MEM.
      instr_op   = 4'b1001;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      tick(); tick();
      chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      tick();
      chk("rst_mid_mem_outs_1", all_outs(), 32'd0);
      tick();
      chk("rst_mid_mem_outs_2", all_outs(), 32'd0);
      rst = 1'b0;
      exp_ret = '0;
      exp_err = 1'b0;
      #1;
      chk("rst_release_imem_req", {31'd0, imem_req}, 32'd1);
      chk("rst_release_mem_req", {31'd0, mem_req}, 32'd0);
      run_instr(4'b0111, 1'b0, 0);

      // HALT: no further fetches until reset.
      instr_op   = 4'b1110;
      imem_ready = 1'b1;
      #1;
      chk("halt_ir_load", {31'd0, ir_load}, 32'd1);
      tick();
      chk("decode_busy", {31'd0, busy}, 32'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
         chk("halt_flags", {30'd0, halted, busy}, 32'd2);
         chk("halt_pc_en", {31'd0, pc_en}, 32'd0);
         tick();
      end
      chk("halt_retired", retired, exp_ret);
      imem_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_ret = '0;
      #1;
      chk("halt_exit_halted", {31'd0, halted}, 32'd0);
      chk("halt_exit_imem_req", {31'd0, imem_req}, 32'd1);
      run_instr(4'b0011, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
